// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with one-cycle register-file write-back
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic [4:0]      rd_addr_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            wb_en_o,
   output logic [4:0]      wb_addr_o,
   output logic [XLEN-1:0] wb_data_o
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t            r_state;
   logic [4:0]        r_cnt;
   logic [2:0]        r_funct3;
   logic [4:0]        r_rd;
   logic              r_neg;
   logic [XLEN-1:0]   r_b;
   logic [2*XLEN-1:0] r_acc;
   logic              r_done;
   logic              r_wb_en;
   logic [4:0]        r_wb_addr;
   logic [XLEN-1:0]   r_wb_data;
   logic              w_sa, w_sb, w_neg, w_div0, w_ovf;
   logic [XLEN-1:0]   w_a_mag, w_b_mag, w_spec, w_hi, w_lo, w_q, w_r, w_res;
   logic [XLEN:0]     w_madd, w_dsh, w_dif;
   logic [2*XLEN-1:0] w_acc_nx, w_pmag, w_prod;
   // Start-time decode: operand signedness, magnitudes, result sign and the divide special cases.
   // r_neg carries the product/quotient sign, or the dividend sign for REM.
   always_comb begin
      w_sa    = op_a_i[XLEN-1] & (funct3_i == 3'b001 | funct3_i == 3'b010 | funct3_i == 3'b100 | funct3_i == 3'b110);
      w_sb    = op_b_i[XLEN-1] & (funct3_i == 3'b001 | funct3_i == 3'b100 | funct3_i == 3'b110);
      w_a_mag = w_sa ? -op_a_i : op_a_i;
      w_b_mag = w_sb ? -op_b_i : op_b_i;
      w_neg   = (funct3_i[2] & funct3_i[1]) ? w_sa : (w_sa ^ w_sb);
      w_div0  = funct3_i[2] & (op_b_i == '0);
      w_ovf   = funct3_i[2] & ~funct3_i[0] & (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (op_b_i == '1);
      w_spec  = funct3_i[1] ? (w_div0 ? op_a_i : '0) : (w_div0 ? '1 : op_a_i);
   end
   // One iteration step: shift-add multiply on {hi,lo}, or restoring divide with remainder in hi and quotient shifting into lo.
   always_comb begin
      w_hi     = r_acc[2*XLEN-1:XLEN];
      w_lo     = r_acc[XLEN-1:0];
      w_madd   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : '0);
      w_dsh    = {w_hi, w_lo[XLEN-1]};
      w_dif    = w_dsh - {1'b0, r_b};
      w_acc_nx = r_funct3[2] ? (w_dif[XLEN] ? {w_dsh[XLEN-1:0], w_lo[XLEN-2:0], 1'b0}
                                            : {w_dif[XLEN-1:0], w_lo[XLEN-2:0], 1'b1})
                             : {w_madd, w_lo[XLEN-1:1]};
      w_pmag   = w_acc_nx;
      w_prod   = r_neg ? -w_pmag : w_pmag;
      w_q      = r_neg ? -w_acc_nx[XLEN-1:0] : w_acc_nx[XLEN-1:0];
      w_r      = r_neg ? -w_acc_nx[2*XLEN-1:XLEN] : w_acc_nx[2*XLEN-1:XLEN];
      w_res    = r_funct3[2] ? (r_funct3[1] ? w_r : w_q)
                             : ((r_funct3 == 3'b000) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
   end
   // Control FSM and datapath; write-back outputs are registered on entry to DONE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_funct3  <= '0;
         r_rd      <= '0;
         r_neg     <= 1'b0;
         r_b       <= '0;
         r_acc     <= '0;
         r_done    <= 1'b0;
         r_wb_en   <= 1'b0;
         r_wb_addr <= '0;
         r_wb_data <= '0;
      end else begin
         r_done  <= 1'b0;
         r_wb_en <= 1'b0;
         case (r_state)
            IDLE: if (start_i) begin
               r_funct3 <= funct3_i;
               r_rd     <= rd_addr_i;
               r_neg    <= w_neg;
               r_b      <= w_b_mag;
               r_acc    <= {{XLEN{1'b0}}, w_a_mag};
               r_cnt    <= '0;
               if (w_div0 | w_ovf) begin
                  r_state   <= DONE;
                  r_done    <= 1'b1;
                  r_wb_en   <= rd_addr_i != '0;
                  r_wb_addr <= rd_addr_i;
                  r_wb_data <= w_spec;
               end else begin
                  r_state <= CALC;
               end
            end
            CALC: begin
               r_acc <= w_acc_nx;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'(XLEN-1)) begin
                  r_state   <= DONE;
                  r_done    <= 1'b1;
                  r_wb_en   <= r_rd != '0;
                  r_wb_addr <= r_rd;
                  r_wb_data <= w_res;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign busy_o    = r_state != IDLE;
   assign done_o    = r_done;
   assign wb_en_o   = r_wb_en;
   assign wb_addr_o = r_wb_addr;
   assign wb_data_o = r_wb_data;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] op_a = '0, op_b = '0;
   logic [4:0]  rd = '0;
   logic        busy, done, wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   int          n_chk = 0, n_err = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .funct3_i(funct3),
      .op_a_i(op_a), .op_b_i(op_b), .rd_addr_i(rd),
      .busy_o(busy), .done_o(done), .wb_en_o(wb_en), .wb_addr_o(wb_addr), .wb_data_o(wb_data)
   );

   always #5 clk = ~clk;

   // Drives one start pulse and reports the write-back seen with its latency in edges (-1 = timeout).
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                        output logic [31:0] data, output int lat, output logic en, output logic [4:0] addr);
      bit got = 0;
      @(posedge clk); #1;
      start = 1'b1; funct3 = f; op_a = a; op_b = b; rd = r;
      lat = 0; data = 'x; en = 1'bx; addr = 'x;
      while (lat < 60 && !got) begin
         @(posedge clk); #1;
         start = 1'b0;
         lat++;
         if (done) begin
            got = 1; data = wb_data; en = wb_en; addr = wb_addr;
         end
      end
      if (!got) lat = -1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if ({busy, done, wb_en, wb_addr, wb_data} !== 40'd0) begin
         n_err++;
         $display("FAIL reset_outputs got busy=%b done=%b en=%b addr=%0d data=%h want all zero", busy, done, wb_en, wb_addr, wb_data);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_mul;
      logic [31:0] d; int l; logic e; logic [4:0] ad;
      do_op(3'b000, 32'h7, 32'hFFFF_FFFD, 5'd5, d, l, e, ad);
      n_chk++; if (l !== 33) begin n_err++; $display("FAIL mul_latency got %0d want 33", l); end
      n_chk++; if (d !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_data got %h want ffffffeb", d); end
      n_chk++; if (e !== 1'b1) begin n_err++; $display("FAIL mul_wb_en got %b want 1", e); end
      n_chk++; if (ad !== 5'd5) begin n_err++; $display("FAIL mul_wb_addr got %0d want 5", ad); end
   endtask

   task automatic test_mulh;
      logic [31:0] d; int l; logic e; logic [4:0] ad;
      logic [2:0]  f[3]  = '{3'b001, 3'b011, 3'b010};
      logic [31:0] a[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] b[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] ex[3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      for (int i = 0; i < 3; i++) begin
         do_op(f[i], a[i], b[i], 5'd9, d, l, e, ad);
         n_chk++;
         if (d !== ex[i] || l !== 33) begin
            n_err++; $display("FAIL mulh_%0d got data=%h lat=%0d want data=%h lat=33", i, d, l, ex[i]);
         end
      end
   endtask

   task automatic test_div;
      logic [31:0] d; int l; logic e; logic [4:0] ad;
      logic [2:0]  f[4]  = '{3'b100, 3'b110, 3'b101, 3'b111};
      logic [31:0] a[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      logic [31:0] b[4]  = '{32'd2, 32'd2, 32'd7, 32'd7};
      logic [31:0] ex[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
      for (int i = 0; i < 4; i++) begin
         do_op(f[i], a[i], b[i], 5'd12, d, l, e, ad);
         n_chk++;
         if (d !== ex[i] || l !== 33) begin
            n_err++; $display("FAIL div_%0d got data=%h lat=%0d want data=%h lat=33", i, d, l, ex[i]);
         end
      end
   endtask

   task automatic test_special;
      logic [31:0] d; int l; logic e; logic [4:0] ad;
      logic [2:0]  f[4]  = '{3'b101, 3'b110, 3'b100, 3'b110};
      logic [31:0] a[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] b[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] ex[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      for (int i = 0; i < 4; i++) begin
         do_op(f[i], a[i], b[i], 5'd3, d, l, e, ad);
         n_chk++;
         if (d !== ex[i] || l !== 1 || e !== 1'b1 || ad !== 5'd3) begin
            n_err++; $display("FAIL special_%0d got data=%h lat=%0d en=%b addr=%0d want data=%h lat=1 en=1 addr=3", i, d, l, e, ad, ex[i]);
         end
      end
   endtask

   task automatic test_rd0;
      logic [31:0] d; int l; logic e; logic [4:0] ad;
      do_op(3'b000, 32'd3, 32'd4, 5'd0, d, l, e, ad);
      n_chk++; if (l !== 33 || d !== 32'd12) begin n_err++; $display("FAIL rd0_done got lat=%0d data=%h want lat=33 data=0000000c", l, d); end
      n_chk++; if (e !== 1'b0) begin n_err++; $display("FAIL rd0_wb_en got %b want 0", e); end
   endtask

   task automatic test_start_held;
      int dones = 0, lat = -1;
      logic [31:0] d = '0;
      logic b1;
      @(posedge clk); #1;
      start = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd3; rd = 5'd7;
      @(posedge clk); #1;
      b1 = busy;
      for (int i = 2; i <= 60 && dones == 0; i++) begin
         @(posedge clk); #1;
         if (done) begin dones++; lat = i; d = wb_data; start = 1'b0; end
      end
      start = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      n_chk++; if (b1 !== 1'b1) begin n_err++; $display("FAIL held_busy got %b want 1", b1); end
      n_chk++; if (lat !== 33 || d !== 32'd6) begin n_err++; $display("FAIL held_result got lat=%0d data=%h want lat=33 data=00000006", lat, d); end
      n_chk++; if (dones !== 1) begin n_err++; $display("FAIL held_done_count got %0d want 1", dones); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d; int l; logic e; logic [4:0] ad;
      int dones = 0;
      @(posedge clk); #1;
      start = 1'b1; funct3 = 3'b111; op_a = 32'd50; op_b = 32'd7; rd = 5'd4;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({busy, done, wb_en, wb_addr, wb_data} !== 40'd0) begin
         n_err++;
         $display("FAIL midreset_outputs got busy=%b done=%b en=%b addr=%0d data=%h want all zero", busy, done, wb_en, wb_addr, wb_data);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || wb_en) dones++;
      end
      n_chk++; if (dones !== 0) begin n_err++; $display("FAIL midreset_no_done got %0d pulses want 0", dones); end
      do_op(3'b101, 32'd9, 32'd3, 5'd2, d, l, e, ad);
      n_chk++; if (d !== 32'd3 || l !== 33) begin n_err++; $display("FAIL midreset_divu got data=%h lat=%0d want data=00000003 lat=33", d, l); end
   endtask

   initial begin
      test_reset;
      test_mul;
      test_mulh;
      test_div;
      test_special;
      test_rd0;
      test_start_held;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit for the RISC-V core. Latches two register-file read operands on a start pulse, computes all eight M-extension results over a fixed number of cycles, and returns a one-cycle write-back request (address, data, enable) that feeds the register file write port. While it is busy it holds the core stalled.

## Interface
- XLEN, 32: operand/result width; the CALC phase lasts XLEN cycles; only 32 is verified.
- clk_i  input  1  core clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- start_i  input  1  request a new operation; sampled only in IDLE.
- funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a_i  input  XLEN  rs1 value (register file rd1).
- op_b_i  input  XLEN  rs2 value (register file rd2).
- rd_addr_i  input  5  destination register.
- busy_o  output  1  high in CALC and DONE; drives the core stall.
- done_o  output  1  one-cycle pulse; the result is valid.
- wb_en_o  output  1  done_o AND (latched rd != 0); the register file write enable.
- wb_addr_o  output  5  latched rd; the register file write address.
- wb_data_o  output  XLEN  result; the register file write data.

## Operation
- States: IDLE, CALC, DONE.
- IDLE with start_i=1:
  - Latch funct3, operands and rd.
  - Compute operand magnitudes and result sign.
  - Next state is CALC, or DONE directly for a special divide case.
- IDLE with start_i=0: remain in IDLE.
- Signedness:
  - MULH, DIV and REM: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MUL, MULHU, DIVU and REMU: both operands unsigned. MUL's low word is sign-agnostic.
- Multiply: radix-2 shift-add on magnitudes into a 2*XLEN accumulator, one bit per CALC cycle.
  - Negate the 2*XLEN product if the sign is negative.
  - MUL returns the low word. MULH, MULHSU and MULHU return the high word.
- Divide: restoring division on magnitudes, one quotient bit per CALC cycle.
  - The quotient is negative when the operand signs differ (signed ops).
  - The remainder takes the dividend's sign.
- Special divide cases (decided at start; skip CALC):
  - op_b == 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a.
  - Signed overflow (DIV/REM, op_a = 0x80000000, op_b = 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- CALC: an internal 5-bit counter runs 0..XLEN-1. After the cycle with count XLEN-1, go to DONE.
- DONE: assert done_o and wb_en_o, present wb_data_o, then return to IDLE unconditionally.
- start_i outside IDLE is ignored and not queued.
- Multiply has no early-out; op_b == 0 takes the full latency.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - busy_o, done_o, wb_en_o = 0; wb_addr_o = 0; wb_data_o = 0.
  - The counter and datapath registers clear.
- Release of reset is synchronous to clk_i. The first start is accepted on the first rising edge with rst_ni high.
- Normal latency: start sampled at edge N. CALC occupies the cycles after edges N+1..N+32. done_o is high for exactly one cycle, between edges N+33 and N+34.
- Special-case latency: done_o is high in the cycle after edge N+1.
- busy_o rises in the cycle after the start edge and falls together with done_o.
  - The core must not issue another M instruction until busy_o is low. A new start can be sampled on the edge ending DONE only if the state is already IDLE; in practice this is the first edge after busy_o falls.
- wb_data_o and wb_addr_o are registered. They hold their last value outside DONE; only done_o and wb_en_o qualify them.
- Reset asserted mid-CALC: the operation is abandoned. No done_o or wb_en_o pulse follows.

## Test plan
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD), rd=5:
  - done_o at start+33; wb_data_o = 0xFFFFFFEB; wb_en_o=1; wb_addr_o=5.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 % 7 -> 2.
  - Each with done_o at start+33.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, REM 5 % 0 -> 5.
  - Overflow: DIV 0x80000000 / -1 -> 0x80000000, REM -> 0.
  - All with done_o at start+1.
- rd=0 MUL 3x4: done_o pulses, wb_en_o stays 0.
  - start_i held high during CALC does not restart; exactly one done_o per accepted start.
- rst_ni pulsed low at CALC count 10: all outputs go to 0 immediately; no done_o afterwards.
  - A fresh DIVU 9/3 after release returns 3 at start+33.
